mux_rr_feeder: RTL

//  Upstream control stage for the 4:1 lane mux. Round-robin arbitrates four lane requests,

---
 rtl/mux_rr_feeder_pkg.sv | 10 +
 rtl/mux_rr_feeder_if.sv | 19 +
 rtl/mux_rr_feeder_rr_pick4.sv | 24 ++
 rtl/mux_rr_feeder.sv | 65 ++++++
 4 files changed

// File: rtl/mux_rr_feeder_pkg.sv
// mux_pkg: shared lane-mux constants, feeder state type and round-robin step helper
package mux_pkg;
  localparam int LANES = 4;
  localparam int SELW = 2;
  localparam int DW = 4;
  typedef enum logic {IDLE, BURST} feed_state_t;
  function automatic logic [SELW-1:0] rr_next(input logic [SELW-1:0] base);
    return base + SELW'(1);
  endfunction
endpackage

// File: rtl/mux_rr_feeder_if.sv
// mux_rr_feeder_if: lane requests/grants, mux select and data, downstream valid/ready output
interface mux_rr_feeder_if #(parameter int DW = 4);
  logic [mux_pkg::LANES-1:0] req;
  logic [mux_pkg::LANES-1:0] gnt;
  logic [mux_pkg::SELW-1:0] sel;
  logic [DW-1:0] y_in;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] out_data;
  logic [mux_pkg::SELW-1:0] out_src;
  modport slave (
    input req, y_in, out_ready,
    output gnt, sel, out_valid, out_data, out_src
  );
  modport master (
    output req, y_in, out_ready,
    input gnt, sel, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_rr_feeder_rr_pick4.sv
// rr_pick4: first set request at base+1, base+2, base+3, then base itself
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] base,
  output logic       any,
  output logic [1:0] idx
);
  import mux_pkg::*;
  always_comb begin
    logic [1:0] b;
    logic found;
    any = |req;
    idx = base;
    b = base;
    found = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      b = rr_next(b);
      if (!found && req[b]) begin
        idx = b;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_rr_feeder.sv
// mux_rr_feeder: round-robin burst arbiter driving the 4:1 lane mux into a registered valid/ready stage
module mux_rr_feeder #(
  parameter int DW = 4,
  parameter int MAX_BURST = 4,
  parameter int CNTW = 3
) (
  input logic clk,
  input logic rst,
  mux_rr_feeder_if.slave bus
);
  import mux_pkg::*;
  feed_state_t state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d, src_q, src_d, pick_idx, rr_idx;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic valid_q, valid_d, rr_any, cont, space, load;
  rr_pick4 u_pick (.req(bus.req), .base(ptr_q), .any(rr_any), .idx(rr_idx));
  always_comb begin
    space = !valid_q || bus.out_ready;
    cont = (state_q == BURST) && bus.req[ptr_q] && (cnt_q < CNTW'(MAX_BURST));
    pick_idx = cont ? ptr_q : rr_idx;
    load = !rst && space && (cont || rr_any);
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    data_d = data_q;
    src_d = src_q;
    valid_d = valid_q;
    if (load) begin
      data_d = bus.y_in;
      src_d = pick_idx;
      valid_d = 1'b1;
      ptr_d = pick_idx;
      cnt_d = cont ? cnt_q + CNTW'(1) : CNTW'(1);
      state_d = (MAX_BURST == 1) ? IDLE : BURST;
    end else if (space) begin
      state_d = IDLE;
      cnt_d = '0;
      valid_d = 1'b0;
    end
  end
  // Stall leaves every register untouched; sel parks on the last granted lane
  assign bus.gnt = load ? (LANES'(1) << pick_idx) : '0;
  assign bus.sel = rst ? '0 : (load ? pick_idx : ptr_q);
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_src = src_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= SELW'(3);
      cnt_q <= '0;
      data_q <= '0;
      src_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      src_q <= src_d;
      valid_q <= valid_d;
    end
  end
endmodule
